// File: rtl/cmp_sar_pkg.sv
// Shared types and sizing helpers for the SAR comparator sequencer.
// Used by cmp_sar_ctrl and cmp_sar_reg.
package cmp_sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EVAL   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Holds either a round index (0..2) or a count of 1-votes (0..3).
  typedef logic [1:0] vote_t;

  localparam int unsigned VOTE_ROUNDS = 3;

  // Phase counter counts 0..max(SETTLE_CYC, TIMEOUT_CYC)-1.
  function automatic int cnt_width(input int settle_cyc, input int timeout_cyc);
    int m;
    m = (settle_cyc > timeout_cyc) ? settle_cyc : timeout_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/cmp_sar_reg.sv
// Trial/keep register of the SAR: loads the MSB trial, resolves one bit per decide
// and arms the next lower trial bit.
module cmp_sar_reg
  import cmp_sar_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int BIT_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              decide_i,
  input  logic              decision_i,
  input  logic [BIT_W-1:0]  bit_idx_i,
  output logic [N_BITS-1:0] dac_code_o,
  output logic [N_BITS-1:0] final_code_o
);

  localparam logic [N_BITS-1:0] LSB_ONE = N_BITS'(1);
  localparam logic [N_BITS-1:0] MSB_ONE = LSB_ONE << (N_BITS - 1);

  logic [N_BITS-1:0] code_q, code_d;
  logic [N_BITS-1:0] mask;

  assign mask         = LSB_ONE << bit_idx_i;
  assign final_code_o = decision_i ? (code_q | mask) : (code_q & ~mask);

  // On the LSB decision mask>>1 is zero, so the code settles on the final result.
  always_comb begin
    code_d = code_q;
    if (load_i) begin
      code_d = MSB_ONE;
    end else if (decide_i) begin
      code_d = final_code_o | (mask >> 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      code_q <= '0;
    end else begin
      code_q <= code_d;
    end
  end

  assign dac_code_o = code_q;

endmodule

// File: rtl/cmp_sar_ctrl.sv
// Successive-approximation sequencer for the UABC latch comparator and reference DAC.
// Define CMP_MAJORITY_EN to decide each bit by a 2-of-3 vote over three evaluate rounds.
module cmp_sar_ctrl
  import cmp_sar_pkg::*;
#(
  parameter int N_BITS      = 8,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cmp_out_i,
  input  logic              cmp_valid_i,
  output logic              cmp_en_o,
  output logic [N_BITS-1:0] dac_code_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_BITS-1:0] result_o,
  output logic              timeout_err_o
);

  localparam int CNT_W = cnt_width(SETTLE_CYC, TIMEOUT_CYC);
  localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [BIT_W-1:0] MSB_IDX      = BIT_W'(N_BITS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              err_q, err_d;
  logic [N_BITS-1:0] result_q, result_d;

  logic              load;
  logic              decide;
  logic              decision;
  logic              round_end;
  logic              vote;
  logic [N_BITS-1:0] final_code;

`ifdef CMP_MAJORITY_EN
  vote_t round_q, round_d;
  vote_t ones_q, ones_d;
`endif

  cmp_sar_reg #(
    .N_BITS (N_BITS),
    .BIT_W  (BIT_W)
  ) u_reg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (load),
    .decide_i     (decide),
    .decision_i   (decision),
    .bit_idx_i    (bit_q),
    .dac_code_o   (dac_code_o),
    .final_code_o (final_code)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
`ifdef CMP_MAJORITY_EN
      round_q  <= '0;
      ones_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      err_q    <= err_d;
      result_q <= result_d;
`ifdef CMP_MAJORITY_EN
      round_q  <= round_d;
      ones_q   <= ones_d;
`endif
    end
  end

  // A round ends on a valid decision or on timeout; a timed-out round votes 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    err_d     = err_q;
    result_d  = result_q;
    load      = 1'b0;
    decide    = 1'b0;
    decision  = 1'b0;
    round_end = 1'b0;
    vote      = 1'b0;
`ifdef CMP_MAJORITY_EN
    round_d   = round_q;
    ones_d    = ones_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = SETTLE;
          cnt_d   = '0;
          bit_d   = MSB_IDX;
          err_d   = 1'b0;
`ifdef CMP_MAJORITY_EN
          round_d = '0;
          ones_d  = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      EVAL: begin
        if (cmp_valid_i) begin
          round_end = 1'b1;
          vote      = cmp_out_i;
        end else if (cnt_q == TIMEOUT_LAST) begin
          round_end = 1'b1;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        if (round_end) begin
          cnt_d   = '0;
          state_d = SETTLE;
`ifdef CMP_MAJORITY_EN
          if (round_q != vote_t'(VOTE_ROUNDS - 1)) begin
            round_d = round_q + 1'b1;
            ones_d  = ones_q + {1'b0, vote};
          end else begin
            decide   = 1'b1;
            decision = ((ones_q + {1'b0, vote}) >= 2'd2);
            round_d  = '0;
            ones_d   = '0;
          end
`else
          decide   = 1'b1;
          decision = vote;
`endif
          if (decide) begin
            if (bit_q == '0) begin
              state_d  = DONE;
              result_d = final_code;
            end else begin
              bit_d = bit_q - 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmp_en_o      = (state_q == EVAL);
  assign busy_o        = (state_q == SETTLE) || (state_q == EVAL);
  assign done_o        = (state_q == DONE);
  assign result_o      = result_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_cmp_sar_ctrl.sv
// Scoreboard bench for cmp_sar_ctrl with a behavioural comparator (cmp_out = vin >= dac_code).
// Build with CMP_MAJORITY_EN to exercise the 2-of-3 voting variant.
module tb_cmp_sar_ctrl;

  localparam int NB = 8;
`ifdef CMP_MAJORITY_EN
  localparam int ROUNDS = 3;
`else
  localparam int ROUNDS = 1;
`endif
  localparam int DONE_CYC = NB * (2 + 1) * ROUNDS + 1;

  typedef struct {
    logic [NB-1:0] res;
    logic          err;
    int            doneCyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          forceInvalid = 1'b0;
  logic [NB-1:0] vin = '0;
  logic          cmpOut, cmpValid, cmpEn, busy, done, timeoutErr, flipVote;
  logic [NB-1:0] dacCode, result;

  int   cyc = 0;
  int   startEdge = 0;
  int   evalIdx = 0;
  int   evalBase = 0;
  int   logBase = 0;
  int   enInWindow = 0;
  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];
  logic [NB-1:0] trialLog[$];

  cmp_sar_ctrl #(
    .N_BITS      (NB),
    .SETTLE_CYC  (2),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .cmp_out_i     (cmpOut),
    .cmp_valid_i   (cmpValid),
    .cmp_en_o      (cmpEn),
    .dac_code_o    (dacCode),
    .busy_o        (busy),
    .done_o        (done),
    .result_o      (result),
    .timeout_err_o (timeoutErr)
  );

  always #5 clk = ~clk;

  // In the voting build the second round of every bit is flipped; majority must still win.
  assign flipVote = (ROUNDS == 3) && (((evalIdx - evalBase) % 3) == 1);
  assign cmpOut   = (vin >= dacCode) ^ flipVote;
  assign cmpValid = cmpEn & ~forceInvalid;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && cmpEn && cmpValid) begin
      trialLog.push_back(dacCode);
      evalIdx <= evalIdx + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (forceInvalid && cmpEn) enInWindow++;
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("result", 32'(result), 32'(e.res));
          checkOutput("dac_final", 32'(dacCode), 32'(e.res));
          checkOutput("timeout_err", 32'(timeoutErr), 32'(e.err));
          checkOutput("done_cycle", cyc - startEdge, e.doneCyc);
          checkOutput("done_busy_en", {busy, cmpEn}, 0);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [NB-1:0] v, input logic [NB-1:0] expRes,
                               input logic expErr, input int expCyc, input bit doPush);
    @(negedge clk);
    vin       = v;
    start     = 1'b1;
    startEdge = cyc;
    logBase   = trialLog.size();
    evalBase  = evalIdx;
    if (doPush) expQ.push_back('{res: expRes, err: expErr, doneCyc: expCyc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitCycle(input int n);
    while (cyc - startEdge < n) @(negedge clk);
  endtask

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    while ((expQ.size() != 0 || busy) && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxCyc) checkOutput("wait_done", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [NB-1:0] expTrial [NB];
    int busyErr;
    expTrial = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

    $display("[TB] starting, rounds per bit = %0d", ROUNDS);
    repeat (3) @(negedge clk);
    checkOutput("rst_cmp_en", 32'(cmpEn), 0);
    checkOutput("rst_dac_code", 32'(dacCode), 0);
    checkOutput("rst_result", 32'(result), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_timeout_err", 32'(timeoutErr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic conversion with busy window check.
    applyStimulus(8'hA5, 8'hA5, 1'b0, DONE_CYC, 1'b1);
    busyErr = 0;
    for (int k = 1; k <= DONE_CYC; k++) begin
      waitCycle(k);
      if (busy !== (k <= DONE_CYC - 1)) busyErr++;
    end
    checkOutput("busy_window", busyErr, 0);
    waitIdle(200);

    // Extremes and the trial-code walk for full scale.
    applyStimulus(8'h00, 8'h00, 1'b0, DONE_CYC, 1'b1);
    waitIdle(200);
    applyStimulus(8'hFF, 8'hFF, 1'b0, DONE_CYC, 1'b1);
    waitIdle(200);
    checkOutput("trial_count", trialLog.size() - logBase, NB * ROUNDS);
    if (trialLog.size() - logBase == NB * ROUNDS) begin
      for (int i = 0; i < NB; i++)
        checkOutput($sformatf("trial_%0d", i), 32'(trialLog[logBase + i * ROUNDS]), 32'(expTrial[i]));
    end

    // start while busy is ignored.
    applyStimulus(8'h3C, 8'h3C, 1'b0, DONE_CYC, 1'b1);
    waitCycle(5);  start = 1'b1;
    waitCycle(6);  start = 1'b0;
    waitCycle(12); start = 1'b1;
    waitCycle(13); start = 1'b0;
    waitIdle(200);
    repeat (30) @(negedge clk);

`ifndef CMP_MAJORITY_EN
    // Bit 5 never gets a valid decision: cleared by timeout, error is sticky.
    applyStimulus(8'hA5, 8'h9F, 1'b1, DONE_CYC + 3, 1'b1);
    waitCycle(8);  forceInvalid = 1'b1;
    waitCycle(13); forceInvalid = 1'b0;
    waitIdle(200);
    checkOutput("timeout_en_cycles", enInWindow, 4);
    repeat (5) @(negedge clk);
    checkOutput("timeout_err_sticky", 32'(timeoutErr), 1);

    // Reset mid-conversion aborts with no done.
    applyStimulus(8'h77, 8'h00, 1'b0, 0, 1'b0);
    checkOutput("err_cleared_on_start", 32'(timeoutErr), 0);
    waitCycle(10); rst = 1'b1;
    waitCycle(11);
    checkOutput("abort_cmp_en", 32'(cmpEn), 0);
    checkOutput("abort_dac_code", 32'(dacCode), 0);
    checkOutput("abort_result", 32'(result), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_timeout_err", 32'(timeoutErr), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    applyStimulus(8'h5A, 8'h5A, 1'b0, DONE_CYC, 1'b1);
    waitIdle(200);
`endif

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
